ri_cpu_mc: RTL and testbench

Multi-cycle successor to the single-cycle R/I-type CPU core. It executes the same MIPS-style R-type and I-type ALU instruction subset through a four-state fetch/decode/execute/writeback FSM. Instructions come from an external instruction memory over a request/valid handshake, so no separate RAM clock is needed. The PC width and reset vector are parametrised, illegal opcodes halt the core, and a debug read port into the register file lets benches check architectural state without probing internals.

---
 rtl/ri_cpu_mc_if.sv | 25 ++
 rtl/ri_cpu_mc.sv | 222 ++++++++++++++++++++++
 tb/tb_ri_cpu_mc.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ri_cpu_mc_if.sv
// Instruction-fetch bus between the multi-cycle core and its instruction memory.
// The core holds the request and word address steady until the memory answers
// with valid data.
interface ri_cpu_mc_if #(
    parameter int IMEM_AW = 6
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/ri_cpu_mc.sv
// Multi-cycle MIPS-style R/I-type ALU core.
// Each instruction goes IF -> ID -> EX -> WB. An illegal instruction parks the
// core in HALT until reset. The debug port reads the register file
// combinationally and sees a same-cycle WB write (write-first).
module ri_cpu_mc #(
    parameter int              PC_W     = 32,
    parameter int              IMEM_AW  = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    ri_cpu_mc_if.master       imem,
    output logic [PC_W-1:0]   pc,
    output logic [31:0]       inst_code,
    output logic [31:0]       alu_f,
    output logic              fr_zf,
    output logic              fr_of,
    output logic              retire,
    output logic              halt,
    input  logic [4:0]        dbg_addr,
    output logic [31:0]       dbg_data
);

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {OP_AND, OP_OR, OP_XOR, OP_NOR,
                              OP_ADD, OP_SUB, OP_SLT, OP_SLL} alu_op_t;

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [31:0]     ir_reg;
    logic [31:0]     a_reg;
    logic [31:0]     b_reg;
    alu_op_t         op_reg;
    logic [4:0]      dest_reg;
    logic [31:0]     alu_f_reg;
    logic            zf_reg;
    logic            of_reg;
    logic            halt_reg;

    // Architectural registers $1..$31; $0 is not stored and always reads zero.
    logic [31:0]     rf [1:31];

    logic            wr_en;
    logic [31:0]     rs_val;
    logic [31:0]     rt_val;
    logic            dec_legal;
    alu_op_t         dec_op;
    logic [31:0]     dec_a;
    logic [31:0]     dec_b;
    logic [4:0]      dec_dest;
    logic [31:0]     alu_res;
    logic            alu_ovf;

    // Field aliases of the instruction register.
    logic [5:0]      opcode;
    logic [5:0]      func;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [15:0]     imm;

    assign opcode = ir_reg[31:26];
    assign rs     = ir_reg[25:21];
    assign rt     = ir_reg[20:16];
    assign rd     = ir_reg[15:11];
    assign shamt  = ir_reg[10:6];
    assign func   = ir_reg[5:0];
    assign imm    = ir_reg[15:0];

    // A reset in the WB cycle suppresses both the write and the retire pulse.
    assign wr_en = (state_reg == S_WB) && !rst && (dest_reg != 5'd0);

    // Register-file write port: one register per generate slot.
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_rf
            // Register gi clears on reset and takes the WB result when addressed.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rf[gi] <= '0;
                end else if (wr_en && (dest_reg == 5'(gi))) begin
                    rf[gi] <= alu_f_reg;
                end
            end
        end
    endgenerate

    // Register-file read ports: rs/rt for decode, write-first debug port.
    always_comb begin
        rs_val   = (rs == 5'd0) ? 32'd0 : rf[rs];
        rt_val   = (rt == 5'd0) ? 32'd0 : rf[rt];
        dbg_data = 32'd0;
        if (dbg_addr != 5'd0) begin
            if (wr_en && (dbg_addr == dest_reg)) begin
                dbg_data = alu_f_reg;
            end else begin
                dbg_data = rf[dbg_addr];
            end
        end
    end

    // Decode the instruction register into ALU op, operands and destination.
    always_comb begin
        dec_legal = 1'b1;
        dec_op    = OP_ADD;
        dec_dest  = rt;
        dec_a     = rs_val;
        dec_b     = {{16{imm[15]}}, imm};
        case (opcode)
            6'b000000: begin
                dec_dest = rd;
                dec_b    = rt_val;
                case (func)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b100110: dec_op = OP_XOR;
                    6'b100111: dec_op = OP_NOR;
                    6'b101010: dec_op = OP_SLT;
                    6'b000000: begin
                        // sll shifts rt, so rt moves to the A side and shamt to B.
                        dec_op = OP_SLL;
                        dec_a  = rt_val;
                        dec_b  = {27'd0, shamt};
                    end
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b001000: dec_op = OP_ADD;
            6'b001010: dec_op = OP_SLT;
            6'b001100: begin dec_op = OP_AND; dec_b = {16'd0, imm}; end
            6'b001101: begin dec_op = OP_OR;  dec_b = {16'd0, imm}; end
            6'b001110: begin dec_op = OP_XOR; dec_b = {16'd0, imm}; end
            default:   dec_legal = 1'b0;
        endcase
    end

    // ALU: result and signed overflow (overflow only meaningful for add/sub).
    always_comb begin
        alu_res = 32'd0;
        alu_ovf = 1'b0;
        case (op_reg)
            OP_AND: alu_res = a_reg & b_reg;
            OP_OR:  alu_res = a_reg | b_reg;
            OP_XOR: alu_res = a_reg ^ b_reg;
            OP_NOR: alu_res = ~(a_reg | b_reg);
            OP_ADD: begin
                alu_res = a_reg + b_reg;
                alu_ovf = (a_reg[31] == b_reg[31]) && (alu_res[31] != a_reg[31]);
            end
            OP_SUB: begin
                alu_res = a_reg - b_reg;
                alu_ovf = (a_reg[31] != b_reg[31]) && (alu_res[31] != a_reg[31]);
            end
            OP_SLT: alu_res = {31'd0, $signed(a_reg) < $signed(b_reg)};
            OP_SLL: alu_res = a_reg << b_reg[4:0];
            default: alu_res = 32'd0;
        endcase
    end

    // Control FSM with its datapath registers; reset overrides every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IF;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= OP_AND;
            dest_reg  <= '0;
            alu_f_reg <= '0;
            zf_reg    <= 1'b0;
            of_reg    <= 1'b0;
            halt_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IF: begin
                    if (imem.imem_valid) begin
                        ir_reg    <= imem.imem_rdata;
                        pc_reg    <= pc_reg + PC_W'(4);
                        state_reg <= S_ID;
                    end
                end
                S_ID: begin
                    if (!dec_legal) begin
                        halt_reg  <= 1'b1;
                        state_reg <= S_HALT;
                    end else begin
                        a_reg     <= dec_a;
                        b_reg     <= dec_b;
                        op_reg    <= dec_op;
                        dest_reg  <= dec_dest;
                        state_reg <= S_EX;
                    end
                end
                S_EX: begin
                    alu_f_reg <= alu_res;
                    zf_reg    <= (alu_res == 32'd0);
                    of_reg    <= alu_ovf;
                    state_reg <= S_WB;
                end
                S_WB:    state_reg <= S_IF;
                S_HALT:  state_reg <= S_HALT;
                default: state_reg <= S_IF;
            endcase
        end
    end

    // Request and retire are gated by rst so neither shows during a reset cycle.
    assign imem.imem_req  = (state_reg == S_IF) && !rst;
    assign imem.imem_addr = pc_reg[IMEM_AW+1:2];
    assign retire         = (state_reg == S_WB) && !rst;
    assign pc             = pc_reg;
    assign inst_code      = ir_reg;
    assign alu_f          = alu_f_reg;
    assign fr_zf          = zf_reg;
    assign fr_of          = of_reg;
    assign halt           = halt_reg;

endmodule

// File: tb/tb_ri_cpu_mc.sv
// Self-checking bench for ri_cpu_mc: directed programs from the test plan plus
// random programs, all compared against an instruction-level reference model.
module tb_ri_cpu_mc;

    localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] inst_code;
    logic [31:0] alu_f;
    logic        fr_zf;
    logic        fr_of;
    logic        retire;
    logic        halt;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_data;

    ri_cpu_mc_if #(.IMEM_AW(6)) bus ();

    ri_cpu_mc #(.PC_W(32), .IMEM_AW(6), .RESET_PC(32'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (bus),
        .pc        (pc),
        .inst_code (inst_code),
        .alu_f     (alu_f),
        .fr_zf     (fr_zf),
        .fr_of     (fr_of),
        .retire    (retire),
        .halt      (halt),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // ---------------- instruction memory with programmable wait states ----------
    logic [31:0] mem [64];
    int          stall = 1000;
    int          wcnt  = 0;

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.imem_req) begin
                bus.imem_valid = (wcnt >= stall);
                bus.imem_rdata = mem[bus.imem_addr];
                wcnt++;
            end else begin
                // Garbage while no request is pending; the core must ignore it.
                wcnt = 0;
                bus.imem_valid = 1'($urandom_range(0, 1));
                bus.imem_rdata = $urandom;
            end
        end
    end

    // ---------------- monitor: retire times and fetch-address stability ----------
    int          cyc = 0;
    int          ret_q[$];
    int          addr_moves = 0;
    int          addr_bad = 0;
    logic        prev_req = 1'b0;
    logic [5:0]  prev_addr = 6'd0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (retire) ret_q.push_back(cyc);
            if (bus.imem_req) begin
                if (prev_req && bus.imem_addr != prev_addr) addr_moves++;
                if (bus.imem_addr != pc[7:2]) addr_bad++;
            end
            prev_req  = bus.imem_req;
            prev_addr = bus.imem_addr;
        end
    end

    // ---------------- reference model (instruction-set level) --------------------
    logic [31:0] m_regs [32];
    logic        m_zf;
    logic        m_of;

    task automatic model_step(input logic [31:0] ins, output bit legal);
        logic [31:0] a, b, r, simm, zimm;
        logic [4:0]  dest;
        int          sa, sb;
        longint      s;
        bit          ov;
        a = m_regs[ins[25:21]];
        b = m_regs[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'd0, ins[15:0]};
        sa = a;
        legal = 1'b1; ov = 1'b0; r = 32'd0; dest = ins[20:16]; s = 0;
        if (ins[31:26] == 6'd0) begin
            dest = ins[15:11];
            sb = b;
            case (ins[5:0])
                6'h20: begin s = longint'(sa) + longint'(sb); r = s[31:0]; end
                6'h22: begin s = longint'(sa) - longint'(sb); r = s[31:0]; end
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
                6'h00: r = b << ins[10:6];
                default: legal = 1'b0;
            endcase
            if (ins[5:0] == 6'h20 || ins[5:0] == 6'h22)
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else begin
            sb = simm;
            case (ins[31:26])
                6'h08: begin
                    s = longint'(sa) + longint'(sb); r = s[31:0];
                    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                6'h0A: r = (sa < sb) ? 32'd1 : 32'd0;
                6'h0C: r = a & zimm;
                6'h0D: r = a | zimm;
                6'h0E: r = a ^ zimm;
                default: legal = 1'b0;
            endcase
        end
        if (legal) begin
            if (dest != 5'd0) m_regs[dest] = r;
            m_zf = (r == 32'd0);
            m_of = ov;
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // ---------------- sequencing helpers ------------------------------------------
    logic [31:0] prog[$];

    task automatic do_reset(input int stall_v);
        @(posedge clk);
        #1 rst = 1'b1;
        stall = stall_v;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ret_q.delete();
        addr_moves = 0;
        addr_bad = 0;
    endtask

    task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
        dbg_addr = 5'(r);
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic check_reset_state(input string tag);
        do_reset(1000);
        @(negedge clk);
        chk({tag, " req"},     {31'd0, bus.imem_req}, 32'd1);
        chk({tag, " addr"},    {26'd0, bus.imem_addr}, 32'd0);
        chk({tag, " pc"},      pc, 32'd0);
        chk({tag, " halt"},    {31'd0, halt}, 32'd0);
        chk({tag, " flags"},   {30'd0, fr_zf, fr_of}, 32'd0);
        chk({tag, " ir"},      inst_code, 32'd0);
        chk({tag, " alu_f"},   alu_f, 32'd0);
        for (int r = 0; r < 32; r++) chk_reg($sformatf("%s r%0d", tag, r), r, 32'd0);
        $display("reset %s: state checked", tag);
    endtask

    // Load prog (terminated by an illegal word), run to halt, compare to model.
    task automatic run_prog(input string name, input int stall_v);
        bit legal;
        int n_ret;
        for (int i = 0; i < 64; i++) mem[i] = (i < prog.size()) ? prog[i] : ILLEGAL;
        for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
        m_zf = 1'b0; m_of = 1'b0; n_ret = 0;
        for (int i = 0; i < 64; i++) begin
            model_step(mem[i], legal);
            if (!legal) break;
            n_ret++;
        end
        do_reset(stall_v);
        for (int i = 0; i < 3000 && halt !== 1'b1; i++) @(negedge clk);
        chk({name, " halted"}, {31'd0, halt}, 32'd1);
        chk({name, " retires"}, ret_q.size(), n_ret);
        for (int i = 1; i < ret_q.size(); i++)
            chk({name, " retire_gap"}, ret_q[i] - ret_q[i-1], 4 + stall_v);
        chk({name, " pc"}, pc, 32'(4 * (n_ret + 1)));
        chk({name, " ir"}, inst_code, mem[n_ret]);
        chk({name, " zf"}, {31'd0, fr_zf}, {31'd0, m_zf});
        chk({name, " of"}, {31'd0, fr_of}, {31'd0, m_of});
        chk({name, " addr_stable"}, addr_moves, 0);
        chk({name, " addr_is_pc"}, addr_bad, 0);
        for (int r = 0; r < 32; r++) chk_reg($sformatf("%s r%0d", name, r), r, m_regs[r]);
        $display("prog %s stall=%0d retired=%0d pc=0x%08h", name, stall_v, ret_q.size(), pc);
    endtask

    task automatic abort_test(input string name, input int lead);
        prog = '{enc_i(6'h08, 5'd0, 5'd7, 16'h0123)};
        for (int i = 0; i < 64; i++) mem[i] = (i < prog.size()) ? prog[i] : ILLEGAL;
        do_reset(0);
        repeat (lead) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 stall = 1000;
        rst = 1'b0;
        chk({name, " no_retire"}, ret_q.size(), 0);
        @(negedge clk);
        chk_reg({name, " r7"}, 7, 32'd0);
        $display("abort %s: reset injected after %0d edges", name, lead);
    endtask

    logic [5:0] r_funcs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};
    logic [5:0] i_ops   [5] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};

    initial begin
        check_reset_state("reset0");

        // ALU chain, no wait states, then with three wait states per fetch.
        prog = '{32'h20017FFF, 32'h00211020, 32'h2003FFFF, 32'h00632022};
        run_prog("chain", 0);
        chk_reg("chain r1", 1, 32'h0000_7FFF);
        chk_reg("chain r2", 2, 32'h0000_FFFE);
        chk_reg("chain r3", 3, 32'hFFFF_FFFF);
        chk_reg("chain r4", 4, 32'h0000_0000);
        chk("chain zf", {31'd0, fr_zf}, 32'd1);
        run_prog("chain_stall", 3);
        chk_reg("stall r2", 2, 32'h0000_FFFE);

        // Overflow, then an ori that clears the flag.
        prog = '{enc_i(6'h0D, 5'd0, 5'd5, 16'hFFFF), enc_r(6'h00, 5'd0, 5'd5, 5'd5, 5'd15),
                 enc_i(6'h0D, 5'd5, 5'd5, 16'h7FFF), enc_i(6'h08, 5'd5, 5'd6, 16'h0001)};
        run_prog("ovf", 0);
        chk_reg("ovf r5", 5, 32'h7FFF_FFFF);
        chk_reg("ovf r6", 6, 32'h8000_0000);
        chk("ovf of", {31'd0, fr_of}, 32'd1);
        prog.push_back(enc_i(6'h0D, 5'd0, 5'd8, 16'h0001));
        run_prog("ovf_clear", 1);
        chk("ovf_clear of", {31'd0, fr_of}, 32'd0);

        // $0 stays zero.
        prog = '{32'h20000005};
        run_prog("zero_reg", 0);
        chk_reg("zero_reg r0", 0, 32'd0);

        // Illegal instruction at 0x8: halt, freeze, then recover through reset.
        prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd1), enc_i(6'h08, 5'd0, 5'd2, 16'd2), ILLEGAL};
        run_prog("illegal", 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt req", {31'd0, bus.imem_req}, 32'd0);
            chk("halt pc", pc, 32'h0000_000C);
        end
        chk("halt retires", ret_q.size(), 2);
        check_reset_state("recover");

        // Reset injected during EX and during WB of an addi.
        abort_test("rst_in_ex", 2);
        abort_test("rst_in_wb", 3);

        // Random legal programs over a small register window, random wait states.
        for (int p = 0; p < 6; p++) begin
            prog.delete();
            for (int k = 1; k < 5; k++)
                prog.push_back(enc_i(6'h08, 5'd0, 5'(k), 16'($urandom)));
            for (int n = 0; n < 10; n++) begin
                int sel;
                sel = $urandom_range(0, 12);
                if (sel < 8)
                    prog.push_back(enc_r(r_funcs[sel], 5'($urandom_range(0, 7)),
                                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                         5'($urandom_range(0, 31))));
                else
                    prog.push_back(enc_i(i_ops[sel-8], 5'($urandom_range(0, 7)),
                                         5'($urandom_range(0, 7)), 16'($urandom)));
            end
            run_prog($sformatf("rand%0d", p), $urandom_range(0, 3));
        end

        check_reset_state("reset_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
